// File: rtl/iz_param_loader.sv
// Byte-serial loader for the Izhikevich neuron parameters: framed, XOR-checked, committed atomically.
// Define IZ_LOADER_DEFAULTS_EN to come out of reset with the regular-spiking set already valid.
module iz_param_loader #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        busy,
    output logic        frame_err
);

`ifdef IZ_LOADER_DEFAULTS_EN
    localparam logic [15:0] RST_A     = 16'd1;
    localparam logic [15:0] RST_B     = 16'd13;
    localparam logic [15:0] RST_C     = 16'hEFC0;
    localparam logic [15:0] RST_D     = 16'd512;
    localparam logic        RST_VALID = 1'b1;
`else
    localparam logic [15:0] RST_A     = 16'd0;
    localparam logic [15:0] RST_B     = 16'd0;
    localparam logic [15:0] RST_C     = 16'd0;
    localparam logic [15:0] RST_D     = 16'd0;
    localparam logic        RST_VALID = 1'b0;
`endif

    // Last idle cycle allowed; one more idle cycle aborts the frame.
    localparam logic [9:0] GAP_LAST = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx;
    logic [7:0]      xr;
    logic [9:0]      gap;
    logic [7:0][7:0] shadow;
    logic            valid_flag;
    logic            take, in_frame, timeout, chk_bad, hdr_take;

    assign in_ready = (state != COMMIT);
    assign busy     = (state != IDLE);
    assign take     = in_valid && in_ready;
    assign in_frame = (state == DATA) || (state == CHECK);
    // An accepted byte always beats an expiring gap counter.
    assign timeout  = in_frame && !take && (gap == GAP_LAST);
    assign chk_bad  = (state == CHECK) && take && (in_data != xr);
    assign hdr_take = (state == IDLE) && take && (in_data == HEADER);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hdr_take) state_nxt = DATA;
            DATA: begin
                if (take && idx == 3'd7) state_nxt = CHECK;
                else if (timeout)        state_nxt = IDLE;
            end
            CHECK: begin
                if (take)         state_nxt = (in_data == xr) ? COMMIT : IDLE;
                else if (timeout) state_nxt = IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= '0;
            xr           <= '0;
            gap          <= '0;
            shadow       <= '0;
            frame_err    <= 1'b0;
            valid_flag   <= RST_VALID;
            params_ready <= RST_VALID;
            param_a      <= RST_A;
            param_b      <= RST_B;
            param_c      <= RST_C;
            param_d      <= RST_D;
        end else begin
            frame_err <= chk_bad || timeout;

            if (take)          gap <= '0;
            else if (in_frame) gap <= gap + 10'd1;

            if (hdr_take) begin
                idx          <= '0;
                xr           <= HEADER;
                params_ready <= 1'b0;
            end

            if (state == DATA && take) begin
                shadow[idx] <= in_data;
                xr          <= xr ^ in_data;
                idx         <= idx + 3'd1;
            end

            // A failed frame leaves the previous set in place and re-exposes it.
            if (chk_bad || timeout) params_ready <= valid_flag;

            if (state == COMMIT) begin
                param_a      <= {shadow[1], shadow[0]};
                param_b      <= {shadow[3], shadow[2]};
                param_c      <= {shadow[5], shadow[4]};
                param_d      <= {shadow[7], shadow[6]};
                valid_flag   <= 1'b1;
                params_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iz_param_loader.sv
// Directed plus randomized frame traffic for iz_param_loader, checked against a frame-level model.
module tb_iz_param_loader;
    localparam logic [7:0] HDR = 8'hA5;

`ifdef IZ_LOADER_DEFAULTS_EN
    localparam logic [3:0][15:0] RST_P = {16'd512, 16'hEFC0, 16'd13, 16'd1};
    localparam logic             RST_V = 1'b1;
`else
    localparam logic [3:0][15:0] RST_P = '0;
    localparam logic             RST_V = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        params_ready, busy, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int exp_err  = 0;
    logic [3:0][15:0] exp_p;
    logic             exp_rdy;

    iz_param_loader #(.HEADER(HDR), .TIMEOUT_CYCLES(1023)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .param_a(param_a), .param_b(param_b), .param_c(param_c),
        .param_d(param_d), .params_ready(params_ready), .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_seen <= err_seen + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it is taken (bounded wait).
    task automatic send(input logic [7:0] b);
        int w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 8) begin
            step();
            w++;
        end
        if (!in_ready) chk("in_ready_stuck", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Frame built straight from the layout: header, a..d little-endian, XOR of everything.
    function automatic logic [9:0][7:0] mk_frame(input logic [3:0][15:0] p);
        logic [9:0][7:0] f;
        f[0] = HDR;
        f[9] = HDR;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = p[i/2][8*(i%2) +: 8];
            f[9]   = f[9] ^ f[i+1];
        end
        return f;
    endfunction

    task automatic check_params(input string tag);
        chk({tag, ".a"}, {16'd0, param_a}, {16'd0, exp_p[0]});
        chk({tag, ".b"}, {16'd0, param_b}, {16'd0, exp_p[1]});
        chk({tag, ".c"}, {16'd0, param_c}, {16'd0, exp_p[2]});
        chk({tag, ".d"}, {16'd0, param_d}, {16'd0, exp_p[3]});
        chk({tag, ".rdy"}, {31'd0, params_ready}, {31'd0, exp_rdy});
        chk({tag, ".errs"}, err_seen, exp_err);
    endtask

    task automatic check_reset(input string tag);
        exp_p   = RST_P;
        exp_rdy = RST_V;
        chk({tag, ".a"}, {16'd0, param_a}, {16'd0, exp_p[0]});
        chk({tag, ".b"}, {16'd0, param_b}, {16'd0, exp_p[1]});
        chk({tag, ".c"}, {16'd0, param_c}, {16'd0, exp_p[2]});
        chk({tag, ".d"}, {16'd0, param_d}, {16'd0, exp_p[3]});
        chk({tag, ".rdy"}, {31'd0, params_ready}, {31'd0, exp_rdy});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".ferr"}, {31'd0, frame_err}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Send a whole frame with random idle gaps; the model keeps the last good set.
    task automatic send_frame(input logic [3:0][15:0] p, input bit bad, input int maxgap);
        logic [9:0][7:0] f;
        f = mk_frame(p);
        if (bad) f[9] = f[9] ^ 8'($urandom_range(1, 255));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) repeat ($urandom_range(0, maxgap)) step();
            send(f[i]);
        end
        step();
        if (bad) exp_err++;
        else begin
            exp_p   = p;
            exp_rdy = 1'b1;
        end
    endtask

    initial begin
        logic [9:0][7:0]  f, g;
        logic [3:0][15:0] p;
        logic [7:0]       junk;

        in_valid = 1'b0;
        in_data  = 8'h00;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Regular-spiking set from the host.
        p = {16'h0200, 16'hEFC0, 16'd13, 16'd1};
        f = mk_frame(p);
        send(f[0]);
        chk("t1.busy_hdr", {31'd0, busy}, 32'd1);
        chk("t1.rdy_hdr", {31'd0, params_ready}, 32'd0);
        for (int i = 1; i < 10; i++) send(f[i]);
        chk("t1.commit_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1.commit_busy", {31'd0, busy}, 32'd1);
        chk("t1.rdy_before", {31'd0, params_ready}, 32'd0);
        step();
        exp_p = p; exp_rdy = 1'b1;
        check_params("t1");
        chk("t1.busy_after", {31'd0, busy}, 32'd0);

        // Bad checksum: old set survives, one error pulse.
        p = {$urandom, $urandom};
        f = mk_frame(p);
        f[9] = f[9] ^ 8'h01;
        for (int i = 0; i < 10; i++) begin
            send(f[i]);
            if (i == 4) chk("t2.rdy_mid", {31'd0, params_ready}, 32'd0);
        end
        chk("t2.ferr", {31'd0, frame_err}, 32'd1);
        chk("t2.busy", {31'd0, busy}, 32'd0);
        chk("t2.rdy", {31'd0, params_ready}, 32'd1);
        step();
        exp_err++;
        chk("t2.ferr_pulse", {31'd0, frame_err}, 32'd0);
        check_params("t2");

        // Junk in IDLE is dropped silently.
        send(8'h00); chk("t3.busy0", {31'd0, busy}, 32'd0);
        send(8'hFF); chk("t3.busy1", {31'd0, busy}, 32'd0);
        send(8'h3C); chk("t3.busy2", {31'd0, busy}, 32'd0);
        step();
        check_params("t3.junk");
        send_frame({$urandom, $urandom}, 1'b0, 2);
        check_params("t3");

        // 1022 idle cycles survive, 1023 abort.
        p = {$urandom, $urandom};
        f = mk_frame(p);
        for (int i = 0; i < 4; i++) send(f[i]);
        repeat (1022) step();
        chk("t4.busy_1022", {31'd0, busy}, 32'd1);
        chk("t4.ferr_1022", {31'd0, frame_err}, 32'd0);
        for (int i = 4; i < 10; i++) send(f[i]);
        step();
        exp_p = p;
        check_params("t4.ok");
        g = mk_frame({$urandom, $urandom});
        for (int i = 0; i < 4; i++) send(g[i]);
        repeat (1022) step();
        chk("t4.busy_pre", {31'd0, busy}, 32'd1);
        step();
        chk("t4.ferr_to", {31'd0, frame_err}, 32'd1);
        chk("t4.busy_to", {31'd0, busy}, 32'd0);
        chk("t4.rdy_to", {31'd0, params_ready}, 32'd1);
        exp_err++;
        step();
        check_params("t4.abort");

        // in_valid held high across COMMIT: a header waits out the stall.
        p = {$urandom, $urandom};
        f = mk_frame(p);
        for (int i = 0; i < 9; i++) send(f[i]);
        in_data = f[9]; in_valid = 1'b1;
        step();
        chk("t5.in_ready_commit", {31'd0, in_ready}, 32'd0);
        in_data = HDR;
        step();
        exp_p = p; exp_rdy = 1'b1;
        check_params("t5.commit");
        chk("t5.in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("t5.busy_idle", {31'd0, busy}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("t5.busy_hdr", {31'd0, busy}, 32'd1);
        chk("t5.rdy_hdr", {31'd0, params_ready}, 32'd0);
        p = {$urandom, $urandom};
        g = mk_frame(p);
        for (int i = 1; i < 10; i++) send(g[i]);
        step();
        exp_p = p;
        check_params("t5.next");

        // Reset mid-frame after five data bytes; the tail must not commit.
        f = mk_frame({16'hDEF1, 16'h9ABC, 16'h5678, 16'h1234});
        for (int i = 0; i < 6; i++) send(f[i]);
        #2 reset_n = 1'b0;
        #1 check_reset("t6.reset");
        @(negedge clk) reset_n = 1'b1;
        step();
        for (int i = 6; i < 10; i++) send(f[i]);
        step();
        check_params("t6.tail");
        chk("t6.busy", {31'd0, busy}, 32'd0);

        // Random traffic: junk, gaps, occasional bad checksum.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == HDR) junk = 8'h5A;
                send(junk);
            end
            send_frame({$urandom, $urandom}, ($urandom_range(0, 3) == 0), 3);
            check_params($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
